// File: rtl/imm_pkg.sv
// imm_pkg: format/opcode encodings and the buffered entry type shared by the immediate generator.
package imm_pkg;
  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  // Entry fields are sized for the widest legal XLEN/tag; instances use the low bits.
  localparam int IMM_MAX = 64;
  localparam int TAG_MAX = 32;
  typedef struct packed {
    logic [IMM_MAX-1:0] imm;
    logic [2:0]         fmt;
    logic               illegal;
    logic [TAG_MAX-1:0] tag;
  } entry_t;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational RISC-V format classification and immediate extraction.
module imm_decode import imm_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     Inst,
  output logic [XLEN-1:0] Imm,
  output logic [2:0]      Fmt,
  output logic            Illegal
);
  logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm, sh_imm;
  logic shift, sh_bad;
  assign i_imm  = XLEN'($signed(Inst[31:20]));
  assign s_imm  = XLEN'($signed({Inst[31:25], Inst[11:7]}));
  assign b_imm  = XLEN'($signed({Inst[31], Inst[7], Inst[30:25], Inst[11:8], 1'b0}));
  assign u_imm  = XLEN'($signed({Inst[31:12], 12'b0}));
  assign j_imm  = XLEN'($signed({Inst[31], Inst[19:12], Inst[20], Inst[30:21], 1'b0}));
  assign sh_imm = XLEN'({XLEN == 64 && Inst[25], Inst[24:20]});
  // funct3 001/101 are SLLI/SRLI/SRAI; shamt bit 5 only exists on RV64.
  assign shift  = Inst[6:0] == OP_IMM && Inst[13:12] == 2'b01;
  assign sh_bad = shift && XLEN == 32 && Inst[25];
  always_comb begin
    Imm = '0;
    Fmt = FMT_ILL;
    Illegal = 1'b1;
    case (Inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin Fmt = FMT_I; Illegal = 1'b0; Imm = shift ? sh_imm : i_imm; end
      OP_STORE:        begin Fmt = FMT_S; Illegal = 1'b0; Imm = s_imm; end
      OP_BRANCH:       begin Fmt = FMT_B; Illegal = 1'b0; Imm = b_imm; end
      OP_LUI, OP_AUIPC: begin Fmt = FMT_U; Illegal = 1'b0; Imm = u_imm; end
      OP_JAL:          begin Fmt = FMT_J; Illegal = 1'b0; Imm = j_imm; end
      OP_REG, OP_REG32: begin Fmt = FMT_R; Illegal = 1'b0; end
      default: ;
    endcase
    if (sh_bad) begin
      Imm = '0;
      Fmt = FMT_ILL;
      Illegal = 1'b1;
    end
  end
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: decode-stage immediate generator feeding a 2-entry skid buffer.
module imm_gen_stage import imm_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Flush,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [31:0]      Inst,
  input  logic [TAG_W-1:0] In_Tag,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [XLEN-1:0]  Imm,
  output logic [2:0]       Fmt,
  output logic             Illegal,
  output logic [TAG_W-1:0] Out_Tag
);
  logic [XLEN-1:0] dec_imm;
  logic [2:0] dec_fmt;
  logic dec_ill;
  entry_t [1:0] mem_q, mem_d;
  entry_t head;
  logic wp_q, wp_d, rp_q, rp_d;
  logic [1:0] cnt_q, cnt_d;
  logic push, pop, unused_head;
  imm_decode #(.XLEN(XLEN)) u_dec (.Inst(Inst), .Imm(dec_imm), .Fmt(dec_fmt), .Illegal(dec_ill));
  assign In_Ready  = (cnt_q < 2'd2) & Rst_n;
  assign Out_Valid = cnt_q != 2'd0;
  // Flush wins: the presented instruction and any pending pop are discarded.
  assign push = In_Valid & In_Ready & ~Flush;
  assign pop  = Out_Valid & Out_Ready & ~Flush;
  assign head = Out_Valid ? mem_q[rp_q] : '0;
  assign Imm     = head.imm[XLEN-1:0];
  assign Fmt     = head.fmt;
  assign Illegal = head.illegal;
  assign Out_Tag = head.tag[TAG_W-1:0];
  assign unused_head = ^{head.imm, head.tag};
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = '{imm: IMM_MAX'(dec_imm), fmt: dec_fmt, illegal: dec_ill, tag: TAG_MAX'(In_Tag)};
    wp_d  = ~Flush & (wp_q ^ push);
    rp_d  = ~Flush & (rp_q ^ pop);
    cnt_d = Flush ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mem_q <= '0;
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
